// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkg
//  Purpose  : Shared types and helpers for the FIFO pointer/flag controller.
//             fifo_op_t encodes {push_ok, pop_ok} so a 2-bit concatenation
//             casts directly onto the operation decode.
//  Revision : 1.0  initial release
// ============================================================================
package fifo_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_t;

    // Number of entries addressed by an ADDR_WIDTH-bit pointer.
    function automatic int unsigned calc_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ctrl_if
//  Purpose  : Request/status bundle between a FIFO client and fifo_ctrl.
//  Signals  : wr, rd, clr_err           client -> controller
//             wr_en, w_addr, r_addr     controller -> register file
//             full, empty, almost_full, almost_empty, count,
//             overflow, underflow       controller -> client
//  Modports : master (client side), slave (controller side)
//  Revision : 1.0  initial release
// ============================================================================
interface fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 2
);
    import fifo_pkg::*;

    logic                  wr;
    logic                  rd;
    logic                  clr_err;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr, rd, clr_err,
        input  wr_en, w_addr, r_addr, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr, rd, clr_err,
        output wr_en, w_addr, r_addr, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ctrl
//  Purpose  : Pointer/flag controller for a register-file FIFO. Converts a
//             push/pop request stream into write strobe and head/tail
//             addresses, tracks occupancy and raises sticky error flags.
//             Holds no data.
//  Ports    : clk    rising-edge clock
//             rst_n  asynchronous active-low reset
//             bus    fifo_ctrl_if.slave (requests in, strobe/addr/flags out)
//  Revision : 1.0  initial release
// ============================================================================
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter int AF_LEVEL   = 2**ADDR_WIDTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    fifo_ctrl_if.slave       bus
);

    localparam int unsigned         c_depth     = calc_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] c_depth_cnt = (ADDR_WIDTH+1)'(c_depth);
    localparam logic [ADDR_WIDTH:0] c_af_level  = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] c_ae_level  = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic                  overflow_q,  overflow_d;
    logic                  underflow_q, underflow_d;

    logic     w_full;
    logic     w_empty;
    logic     w_push_ok;
    logic     w_pop_ok;
    fifo_op_t w_op;

    // Flags decode from registered count only, so they never glitch.
    assign w_full  = (count_q == c_depth_cnt);
    assign w_empty = (count_q == '0);

    // A push while full is still legal if a pop vacates the head slot on the
    // same edge; the write then lands on the slot being freed.
    assign w_push_ok = bus.wr & (~w_full | bus.rd);
    assign w_pop_ok  = bus.rd & ~w_empty;
    assign w_op      = fifo_op_t'({w_push_ok, w_pop_ok});

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        case (w_op)
            OP_PUSH: begin
                wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
                count_d  = count_q + (ADDR_WIDTH+1)'(1);
            end
            OP_POP: begin
                rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
                count_d  = count_q - (ADDR_WIDTH+1)'(1);
            end
            OP_BOTH: begin
                wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
                rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            end
            default: ;
        endcase

        // New error events take priority over a coincident clear.
        overflow_d  = (bus.wr & w_full & ~bus.rd) | (overflow_q  & ~bus.clr_err);
        underflow_d = (bus.rd & w_empty)          | (underflow_q & ~bus.clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.wr_en        = w_push_ok;
    assign bus.w_addr       = wr_ptr_q;
    assign bus.r_addr       = rd_ptr_q;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (count_q >= c_af_level);
    assign bus.almost_empty = (count_q <= c_ae_level);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_ctrl
//  Purpose  : Directed self-checking bench for fifo_ctrl (ADDR_WIDTH=2,
//             DEPTH=4, AF_LEVEL=3, AE_LEVEL=1) with a small register-file
//             model supplying r_data.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic [7:0] mem [4];
    logic [7:0] r_data;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    fifo_ctrl_if #(.ADDR_WIDTH(2)) bus ();

    fifo_ctrl #(
        .ADDR_WIDTH (2),
        .AF_LEVEL   (3),
        .AE_LEVEL   (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Register file model: synchronous write, combinational read.
    always @(posedge clk) if (bus.wr_en) mem[bus.w_addr] <= din;
    assign r_data = mem[bus.r_addr];

    task automatic drive(input logic w, input logic r, input logic c, input logic [7:0] d);
        bus.wr = w; bus.rd = r; bus.clr_err = c; din = d;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 8'h00);
        step(); step();
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", bus.full); end
        total++; if (bus.almost_empty !== 1'b1) begin bad++; $display("FAIL reset_ae: got %b want 1", bus.almost_empty); end
        total++; if (bus.almost_full !== 1'b0) begin bad++; $display("FAIL reset_af: got %b want 0", bus.almost_full); end
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
        total++; if ({bus.overflow, bus.underflow} !== 2'b00) begin bad++; $display("FAIL reset_err: got %b want 00", {bus.overflow, bus.underflow}); end
        total++; if ({bus.w_addr, bus.r_addr} !== 4'h0) begin bad++; $display("FAIL reset_ptrs: got %h want 0", {bus.w_addr, bus.r_addr}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fill_drain();
        logic [2:0] exp_cnt [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic       exp_af  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       exp_fl  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0] exp_wa  [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [7:0] vals    [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        logic [2:0] exp_dc  [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, vals[i]); #1;
            total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL fill_wr_en[%0d]: got %b want 1", i, bus.wr_en); end
            step();
            total++; if (bus.count !== exp_cnt[i]) begin bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.count, exp_cnt[i]); end
            total++; if (bus.almost_full !== exp_af[i]) begin bad++; $display("FAIL fill_af[%0d]: got %b want %b", i, bus.almost_full, exp_af[i]); end
            total++; if (bus.full !== exp_fl[i]) begin bad++; $display("FAIL fill_full[%0d]: got %b want %b", i, bus.full, exp_fl[i]); end
            total++; if (bus.w_addr !== exp_wa[i]) begin bad++; $display("FAIL fill_waddr[%0d]: got %0d want %0d", i, bus.w_addr, exp_wa[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 8'h00);
            total++; if (r_data !== vals[i]) begin bad++; $display("FAIL drain_data[%0d]: got %h want %h", i, r_data, vals[i]); end
            step();
            total++; if (bus.count !== exp_dc[i]) begin bad++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, bus.count, exp_dc[i]); end
        end
        drive(0, 0, 0, 8'h00);
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL drain_empty: got %b want 1", bus.empty); end
        total++; if ({bus.overflow, bus.underflow} !== 2'b00) begin bad++; $display("FAIL drain_err: got %b want 00", {bus.overflow, bus.underflow}); end
    endtask

    task automatic test_overflow();
        logic [7:0] vals [4] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        logic [7:0] outv [4] = '{8'hB1, 8'hB2, 8'hB3, 8'hC0};
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, vals[i]); step();
        end
        drive(1, 0, 0, 8'hEE); #1;
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL ovf_wr_en: got %b want 0", bus.wr_en); end
        step();
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
        total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d want 4", bus.count); end
        total++; if (bus.w_addr !== 2'd0) begin bad++; $display("FAIL ovf_waddr: got %0d want 0", bus.w_addr); end
        drive(1, 1, 0, 8'hC0); #1;
        total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL full_both_wr_en: got %b want 1", bus.wr_en); end
        step();
        drive(0, 0, 0, 8'h00);
        total++; if (bus.count !== 3'd4 || bus.full !== 1'b1) begin bad++; $display("FAIL full_both_count: got %0d/%b want 4/1", bus.count, bus.full); end
        total++; if ({bus.w_addr, bus.r_addr} !== 4'b0101) begin bad++; $display("FAIL full_both_ptrs: got %b want 0101", {bus.w_addr, bus.r_addr}); end
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL full_both_ovf: got %b want 1", bus.overflow); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 8'h00);
            total++; if (r_data !== outv[i]) begin bad++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, r_data, outv[i]); end
            step();
        end
        drive(0, 0, 1, 8'h00); step();
        drive(0, 0, 0, 8'h00);
        total++; if (bus.overflow !== 1'b0 || bus.empty !== 1'b1) begin bad++; $display("FAIL ovf_clear: got ovf=%b empty=%b want 0/1", bus.overflow, bus.empty); end
    endtask

    task automatic test_empty_both();
        drive(1, 1, 0, 8'h5C); #1;
        total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL eb_wr_en: got %b want 1", bus.wr_en); end
        step();
        drive(0, 0, 0, 8'h00);
        total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL eb_count: got %0d want 1", bus.count); end
        total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL eb_unf: got %b want 1", bus.underflow); end
        total++; if (r_data !== 8'h5C) begin bad++; $display("FAIL eb_data: got %h want 5c", r_data); end
        total++; if ({bus.w_addr, bus.r_addr} !== 4'b1001) begin bad++; $display("FAIL eb_ptrs: got %b want 1001", {bus.w_addr, bus.r_addr}); end
        drive(0, 0, 1, 8'h00); step();
        total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL eb_clear: got %b want 0", bus.underflow); end
        drive(0, 1, 0, 8'h00); step();
        drive(0, 0, 0, 8'h00);
        total++; if (bus.empty !== 1'b1 || bus.underflow !== 1'b0) begin bad++; $display("FAIL eb_pop: got empty=%b unf=%b want 1/0", bus.empty, bus.underflow); end
    endtask

    task automatic test_alternate();
        logic [7:0] v;
        for (int i = 0; i < 10; i++) begin
            v = 8'h10 + 8'(i);
            drive(1, 0, 0, v); step();
            total++; if (r_data !== v) begin bad++; $display("FAIL alt_data[%0d]: got %h want %h", i, r_data, v); end
            total++; if (bus.count !== 3'd1 || bus.almost_empty !== 1'b1) begin bad++; $display("FAIL alt_cnt1[%0d]: got %0d/%b want 1/1", i, bus.count, bus.almost_empty); end
            drive(0, 1, 0, 8'h00); step();
            total++; if (bus.count !== 3'd0 || bus.almost_empty !== 1'b1) begin bad++; $display("FAIL alt_cnt0[%0d]: got %0d/%b want 0/1", i, bus.count, bus.almost_empty); end
        end
        drive(0, 0, 0, 8'h00);
        // Pointers started at 2; ten pairs land both on (2+10) mod 4 = 0.
        total++; if ({bus.w_addr, bus.r_addr} !== 4'b0000) begin bad++; $display("FAIL alt_ptrs: got %b want 0000", {bus.w_addr, bus.r_addr}); end
        total++; if ({bus.overflow, bus.underflow} !== 2'b00) begin bad++; $display("FAIL alt_err: got %b want 00", {bus.overflow, bus.underflow}); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 8'h60 + 8'(i)); step();
        end
        drive(0, 0, 0, 8'h00);
        total++; if (bus.count !== 3'd3 || bus.w_addr !== 2'd3) begin bad++; $display("FAIL ar_pre: got %0d/%0d want 3/3", bus.count, bus.w_addr); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.empty !== 1'b1 || bus.count !== 3'd0) begin bad++; $display("FAIL ar_flags: got empty=%b count=%0d want 1/0", bus.empty, bus.count); end
        total++; if ({bus.w_addr, bus.r_addr} !== 4'b0000) begin bad++; $display("FAIL ar_ptrs: got %b want 0000", {bus.w_addr, bus.r_addr}); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_set_wins();
        drive(0, 1, 1, 8'h00); step();
        total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL sw_unf: got %b want 1", bus.underflow); end
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL sw_count: got %0d want 0", bus.count); end
        drive(0, 0, 1, 8'h00); step();
        drive(0, 0, 0, 8'h00);
        total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL sw_clear: got %b want 0", bus.underflow); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_empty_both();
        test_alternate();
        test_async_reset();
        test_set_wins();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
